// File: rtl/booth4_ctrl_if.sv
// booth4_ctrl_if: signal bundle between the radix-4 Booth control unit and
// its datapath. The datapath side (master) supplies the start request and
// the current Q recoding triplet. The control side (slave) returns the
// register strobes, the adder mode bits and busy.
interface booth4_ctrl_if;
  logic bgn;
  logic q1;
  logic q0;
  logic qm1;
  logic c0;
  logic c1;
  logic c2;
  logic c3;
  logic c4;
  logic c5;
  logic c6;
  logic sub;
  logic m2;
  logic busy;

  modport master (
    output bgn, q1, q0, qm1,
    input  c0, c1, c2, c3, c4, c5, c6, sub, m2, busy
  );

  modport slave (
    input  bgn, q1, q0, qm1,
    output c0, c1, c2, c3, c4, c5, c6, sub, m2, busy
  );
endinterface

// File: rtl/booth4_ctrl.sv
// booth4_ctrl: sequencer for an 8-bit radix-4 Booth multiplier datapath.
// It loads M and then Q, runs four EVAL/ADD/SHIFT iterations, drives the
// A and Q halves of the result onto the bus, and then pulses c6.
// All outputs are decoded from registered state only (Moore outputs).
// Optional macro BOOTH4_ZERO_SKIP_EN: when the recoded op is zero, EVAL
// goes straight to SHIFT, so latency varies from 13 to 17 cycles. Without
// the macro, ADD is always visited and latency is a constant 17 cycles.
module booth4_ctrl (
  input  logic clk,
  input  logic rst_b,
  booth4_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, LD_M, LD_Q, EVAL, ADD, SHIFT, OUT_A, OUT_Q, DONE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  cnt;
  logic [2:0]  trip;
  logic        trip_zero;
  logic        trip_sub;
  logic        trip_m2;

  // Triplets 000 and 111 recode to "add nothing".
  function automatic logic op_is_zero(input logic [2:0] t);
    return (t == 3'b000) || (t == 3'b111);
  endfunction

  assign trip_zero = op_is_zero(trip);
  assign trip_sub  = trip[2] & ~(trip[1] & trip[0]);
  assign trip_m2   = (trip == 3'b011) || (trip == 3'b100);

  // State register; reset returns to IDLE without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= next_state;
  end

  // Iteration counter and the triplet captured in EVAL for use in ADD.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt  <= 2'd0;
      trip <= 3'b000;
    end else begin
      if (state == IDLE && bus.bgn) cnt <= 2'd0;
      else if (state == SHIFT)      cnt <= cnt + 2'd1;
      if (state == EVAL) trip <= {bus.q1, bus.q0, bus.qm1};
    end
  end

  // Next-state sequencing.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.bgn) next_state = LD_M;
      LD_M:  next_state = LD_Q;
      LD_Q:  next_state = EVAL;
      EVAL: begin
`ifdef BOOTH4_ZERO_SKIP_EN
        if (op_is_zero({bus.q1, bus.q0, bus.qm1})) next_state = SHIFT;
        else                                        next_state = ADD;
`else
        next_state = ADD;
`endif
      end
      ADD:   next_state = SHIFT;
      SHIFT: next_state = (cnt == 2'd3) ? OUT_A : EVAL;
      OUT_A: next_state = OUT_Q;
      OUT_Q: next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore output decode; the adder mode bits are qualified by c2.
  always_comb begin
    bus.c0   = 1'b0;
    bus.c1   = 1'b0;
    bus.c2   = 1'b0;
    bus.c3   = 1'b0;
    bus.c4   = 1'b0;
    bus.c5   = 1'b0;
    bus.c6   = 1'b0;
    bus.sub  = 1'b0;
    bus.m2   = 1'b0;
    bus.busy = (state != IDLE);
    case (state)
      LD_M:  bus.c0 = 1'b1;
      LD_Q:  bus.c1 = 1'b1;
      ADD: begin
        if (!trip_zero) begin
          bus.c2  = 1'b1;
          bus.sub = trip_sub;
          bus.m2  = trip_m2;
        end
      end
      SHIFT: bus.c3 = 1'b1;
      OUT_A: bus.c4 = 1'b1;
      OUT_Q: bus.c5 = 1'b1;
      DONE:  bus.c6 = 1'b1;
      default: ;
    endcase
  end

endmodule
